// File: rtl/cart_loader_if.sv
// Byte-stream, status and ROM-programming signals of the cartridge loader.
// The master modport is the loader side, the slave modport is the UART/ROM side.
interface cart_loader_if #(
    parameter int ADDR_W = 15
);
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              tx_valid;
    logic [7:0]        tx_data;
    logic              tx_ready;
    logic              prog_we;
    logic              prog_sel;
    logic [ADDR_W-1:0] prog_addr;
    logic [7:0]        prog_data;

    modport master (
        input  rx_valid, rx_data, tx_ready,
        output rx_ready, tx_valid, tx_data,
        output prog_we, prog_sel, prog_addr, prog_data
    );

    modport slave (
        output rx_valid, rx_data, tx_ready,
        input  rx_ready, tx_valid, tx_data,
        input  prog_we, prog_sel, prog_addr, prog_data
    );
endinterface

// File: rtl/cart_loader.sv
// iNES cartridge loader: validates the header, streams PRG then CHR bytes into
// the ROM programming port and reports one status character over UART TX.
module cart_loader #(
    parameter logic [31:0] MAGIC         = 32'h4E45531A,
    parameter int          HDR_LEN       = 16,
    parameter int          PRG_UNIT      = 16384,
    parameter int          CHR_UNIT      = 8192,
    parameter int          MAX_PRG_BANKS = 2,
    parameter int          MAX_CHR_BANKS = 1,
    parameter int          MAPPER_ID     = 0,
    parameter int          ADDR_W        = 15,
    parameter int          TIMEOUT_CYC   = 1000000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    cart_loader_if.master bus,
    output logic         busy,
    output logic         cart_ready,
    output logic [7:0]   status,
    output logic [7:0]   prg_banks,
    output logic [7:0]   chr_banks,
    output logic         mirror_v
);
    localparam int LEN_W  = ADDR_W + 1;
    localparam int CNT_W  = $clog2(HDR_LEN);
    localparam int TMO_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int PRG_SH = $clog2(PRG_UNIT);
    localparam int CHR_SH = $clog2(CHR_UNIT);

    localparam logic [7:0] CODE_S = 8'h53;
    localparam logic [7:0] CODE_F = 8'h46;
    localparam logic [7:0] CODE_M = 8'h4D;
    localparam logic [7:0] CODE_T = 8'h54;

    typedef enum logic [2:0] {
        IDLE, HEADER, CHECK, PRG, CHR, REPORT, READY
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [LEN_W-1:0]  offset_q, offset_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [7:0]        status_q, status_d;
    logic [7:0]        prg_banks_q, prg_banks_d;
    logic [7:0]        chr_banks_q, chr_banks_d;
    logic              mirror_q, mirror_d;
    logic              trainer_q, trainer_d;
    logic [3:0]        map_lo_q, map_lo_d;
    logic [3:0]        map_hi_q, map_hi_d;
    logic              prog_we_q, prog_we_d;
    logic              prog_sel_q, prog_sel_d;
    logic [ADDR_W-1:0] prog_addr_q, prog_addr_d;
    logic [7:0]        prog_data_q, prog_data_d;

    logic             rx_ready;
    logic             accept;
    logic             tmo_hit;
    logic [7:0]       magic_byte;
    logic [LEN_W-1:0] prg_len;
    logic [LEN_W-1:0] chr_len;
    logic             bad_image;

    assign rx_ready = (state_q == HEADER) || (state_q == PRG) || (state_q == CHR);
    assign accept   = bus.rx_valid && rx_ready;
    assign tmo_hit  = (tmo_q == TMO_W'(TIMEOUT_CYC - 1));
    assign prg_len  = LEN_W'(prg_banks_q) << PRG_SH;
    assign chr_len  = LEN_W'(chr_banks_q) << CHR_SH;

    assign bad_image = (prg_banks_q == 8'd0)
                    || (prg_banks_q > 8'(MAX_PRG_BANKS))
                    || (chr_banks_q > 8'(MAX_CHR_BANKS))
                    || trainer_q
                    || ({map_hi_q, map_lo_q} != 8'(MAPPER_ID));

    always_comb begin
        magic_byte = MAGIC[31:24];
        case (cnt_q[1:0])
            2'd1:    magic_byte = MAGIC[23:16];
            2'd2:    magic_byte = MAGIC[15:8];
            2'd3:    magic_byte = MAGIC[7:0];
            default: magic_byte = MAGIC[31:24];
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        offset_d    = offset_q;
        tmo_d       = tmo_q;
        status_d    = status_q;
        prg_banks_d = prg_banks_q;
        chr_banks_d = chr_banks_q;
        mirror_d    = mirror_q;
        trainer_d   = trainer_q;
        map_lo_d    = map_lo_q;
        map_hi_d    = map_hi_q;
        prog_we_d   = 1'b0;
        prog_sel_d  = prog_sel_q;
        prog_addr_d = prog_addr_q;
        prog_data_d = prog_data_q;

        case (state_q)
            IDLE, READY: begin
                if (start) begin
                    state_d = HEADER;
                    cnt_d   = '0;
                    tmo_d   = '0;
                end
            end
            HEADER: begin
                if (accept) begin
                    tmo_d = '0;
                    cnt_d = cnt_q + CNT_W'(1);
                    if ((cnt_q < CNT_W'(4)) && (bus.rx_data != magic_byte)) begin
                        state_d  = REPORT;
                        status_d = CODE_F;
                    end else begin
                        case (cnt_q)
                            CNT_W'(4): prg_banks_d = bus.rx_data;
                            CNT_W'(5): chr_banks_d = bus.rx_data;
                            CNT_W'(6): begin
                                mirror_d  = bus.rx_data[0];
                                trainer_d = bus.rx_data[2];
                                map_lo_d  = bus.rx_data[7:4];
                            end
                            CNT_W'(7): map_hi_d = bus.rx_data[7:4];
                            default: ;
                        endcase
                        if (cnt_q == CNT_W'(HDR_LEN - 1))
                            state_d = CHECK;
                    end
                end else if (tmo_hit) begin
                    state_d  = REPORT;
                    status_d = CODE_T;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            CHECK: begin
                if (bad_image) begin
                    state_d  = REPORT;
                    status_d = CODE_M;
                end else begin
                    state_d  = PRG;
                    offset_d = '0;
                    tmo_d    = '0;
                end
            end
            // PRG and CHR share the write path; the region select and length differ
            PRG, CHR: begin
                if (accept) begin
                    tmo_d       = '0;
                    prog_we_d   = 1'b1;
                    prog_sel_d  = (state_q == CHR);
                    prog_addr_d = offset_q[ADDR_W-1:0];
                    prog_data_d = bus.rx_data;
                    offset_d    = offset_q + LEN_W'(1);
                    if (state_q == PRG && offset_q == prg_len - LEN_W'(1)) begin
                        if (chr_banks_q == 8'd0) begin
                            state_d  = REPORT;
                            status_d = CODE_S;
                        end else begin
                            state_d  = CHR;
                            offset_d = '0;
                        end
                    end else if (state_q == CHR && offset_q == chr_len - LEN_W'(1)) begin
                        state_d  = REPORT;
                        status_d = CODE_S;
                    end
                end else if (tmo_hit) begin
                    state_d  = REPORT;
                    status_d = CODE_T;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            REPORT: begin
                if (bus.tx_ready)
                    state_d = (status_q == CODE_S) ? READY : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            offset_q    <= '0;
            tmo_q       <= '0;
            status_q    <= '0;
            prg_banks_q <= '0;
            chr_banks_q <= '0;
            mirror_q    <= 1'b0;
            trainer_q   <= 1'b0;
            map_lo_q    <= '0;
            map_hi_q    <= '0;
            prog_we_q   <= 1'b0;
            prog_sel_q  <= 1'b0;
            prog_addr_q <= '0;
            prog_data_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            offset_q    <= offset_d;
            tmo_q       <= tmo_d;
            status_q    <= status_d;
            prg_banks_q <= prg_banks_d;
            chr_banks_q <= chr_banks_d;
            mirror_q    <= mirror_d;
            trainer_q   <= trainer_d;
            map_lo_q    <= map_lo_d;
            map_hi_q    <= map_hi_d;
            prog_we_q   <= prog_we_d;
            prog_sel_q  <= prog_sel_d;
            prog_addr_q <= prog_addr_d;
            prog_data_q <= prog_data_d;
        end
    end

    assign bus.rx_ready  = rx_ready;
    assign bus.tx_valid  = (state_q == REPORT);
    assign bus.tx_data   = (state_q == REPORT) ? status_q : 8'h00;
    assign bus.prog_we   = prog_we_q;
    assign bus.prog_sel  = prog_sel_q;
    assign bus.prog_addr = prog_addr_q;
    assign bus.prog_data = prog_data_q;

    assign busy       = (state_q == HEADER) || (state_q == PRG) || (state_q == CHR)
                     || (state_q == REPORT);
    assign cart_ready = (state_q == READY);
    assign status     = status_q;
    assign prg_banks  = prg_banks_q;
    assign chr_banks  = chr_banks_q;
    assign mirror_v   = mirror_q;
endmodule

// File: tb/tb_cart_loader.sv
// Directed bench for cart_loader with small bank units: an image-level model
// predicts every ROM write and the status code; a monitor checks them each cycle.
module tb_cart_loader;
    localparam int AW  = 5;
    localparam int TMO = 50;

    typedef logic [7:0] byte_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic busy, cart_ready, mirror_v;
    logic [7:0] status, prg_banks, chr_banks;

    always #5 clk = ~clk;

    cart_loader_if #(.ADDR_W(AW)) bus ();

    cart_loader #(
        .PRG_UNIT(16), .CHR_UNIT(8), .ADDR_W(AW), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .bus(bus.master),
        .busy(busy), .cart_ready(cart_ready), .status(status),
        .prg_banks(prg_banks), .chr_banks(chr_banks), .mirror_v(mirror_v)
    );

    int checks = 0;
    int errors = 0;
    byte_t img[$];
    logic [13:0] exp_q[$];
    logic [7:0] exp_code = 8'h00;
    logic exp_ready = 1'b0;
    int wr_seen = 0;
    int tx_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every ROM write, every status handshake and rx_ready in READY
    always @(negedge clk) begin
        if (rst) begin
            if (bus.prog_we) begin
                wr_seen++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_write: got sel=%0d addr=%0d data=0x%0h, expected none",
                             bus.prog_sel, bus.prog_addr, bus.prog_data);
                end else begin
                    check("prog_write", 32'({bus.prog_sel, bus.prog_addr, bus.prog_data}),
                          32'(exp_q.pop_front()));
                end
            end
            if (bus.tx_valid && bus.tx_ready) begin
                tx_seen++;
                check("tx_code", 32'(bus.tx_data), 32'(exp_code));
            end
            if (cart_ready)
                check("rx_ready_in_ready", 32'(bus.rx_ready), 0);
        end
    end

    task automatic build(input byte_t b4, input byte_t b5, input byte_t b6, input byte_t b7,
                         input int np, input int nc);
        img.delete();
        img.push_back(8'h4E); img.push_back(8'h45); img.push_back(8'h53); img.push_back(8'h1A);
        img.push_back(b4); img.push_back(b5); img.push_back(b6); img.push_back(b7);
        for (int i = 0; i < 8; i++) img.push_back(8'h00);
        for (int i = 0; i < np * 16; i++) img.push_back(byte_t'(i));
        for (int i = 0; i < nc * 8; i++) img.push_back(byte_t'(8'hF0 + i));
    endtask

    // Image-level outcome: which payload bytes land where, and which code is sent
    task automatic model(input int stall_at, input int stall_len);
        logic [31:0] magic = 32'h4E45531A;
        int consumed, np, nc, idx;
        byte_t b6, b7, mapper;
        logic done = 1'b0;
        exp_q.delete();
        consumed = 16;
        for (int n = 0; n < 4; n++) begin
            if (!done && img[n] != magic[31 - 8*n -: 8]) begin
                exp_code = 8'h46;
                consumed = n + 1;
                done = 1'b1;
            end
        end
        np = int'(img[4]);
        nc = int'(img[5]);
        b6 = img[6];
        b7 = img[7];
        mapper = {b7[7:4], b6[7:4]};
        if (!done) begin
            if (np == 0 || np > 2 || nc > 1 || b6[2] || mapper != 8'h00) begin
                exp_code = 8'h4D;
            end else begin
                exp_code = 8'h53;
                consumed = 16 + np * 16 + nc * 8;
            end
        end
        if (stall_len >= TMO && stall_at >= 0 && stall_at < consumed) begin
            exp_code = 8'h54;
            consumed = stall_at;
        end
        if (exp_code == 8'h53 || exp_code == 8'h54) begin
            for (int k = 16; k < consumed; k++) begin
                idx = k - 16;
                if (idx < np * 16) exp_q.push_back({1'b0, 5'(idx), img[k]});
                else               exp_q.push_back({1'b1, 5'(idx - np * 16), img[k]});
            end
        end
        exp_ready = (exp_code == 8'h53);
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic applyStimulus(input int stall_at, input int stall_len, input int limit);
        int i = 0, guard = 0, not_rdy = 0, stall_left = stall_len;
        while (i < limit && guard < 5000) begin
            @(negedge clk);
            guard++;
            if (!bus.rx_ready) begin
                bus.rx_valid = 1'b0;
                not_rdy++;
                if (not_rdy > 4) break;
            end else begin
                not_rdy = 0;
                if (i == stall_at && stall_left > 0) begin
                    bus.rx_valid = 1'b0;
                    stall_left--;
                end else begin
                    bus.rx_valid = 1'b1;
                    bus.rx_data  = img[i];
                    i++;
                end
            end
        end
    endtask

    task automatic checkOutput(input string name, input int stall_at, input int stall_len,
                               input int hold, output int nw);
        int wr0, tx0, k;
        model(stall_at, stall_len);
        wr0 = wr_seen;
        tx0 = tx_seen;
        if (hold > 0) bus.tx_ready = 1'b0;
        pulse_start();
        applyStimulus(stall_at, stall_len, img.size());
        @(negedge clk) bus.rx_valid = 1'b0;
        if (hold > 0) begin
            k = 0;
            while (!bus.tx_valid && k < 300) begin @(negedge clk); k++; end
            check({name, "_tx_valid_rise"}, 32'(bus.tx_valid), 1);
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                check({name, "_hold_valid"}, 32'(bus.tx_valid), 1);
                check({name, "_hold_data"}, 32'(bus.tx_data), 'h53);
            end
            bus.tx_ready = 1'b1;
        end
        k = 0;
        while (tx_seen == tx0 && k < 300) begin @(negedge clk); k++; end
        if (tx_seen == tx0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_report_timeout: got no status byte, expected 0x%0h", name, exp_code);
        end
        @(negedge clk);
        check({name, "_writes_left"}, 32'(exp_q.size()), 0);
        check({name, "_cart_ready"}, 32'(cart_ready), 32'(exp_ready));
        check({name, "_status"}, 32'(status), 32'(exp_code));
        nw = wr_seen - wr0;
    endtask

    initial begin
        int nw;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_prog_we", 32'(bus.prog_we), 0);
        check("rst_tx_valid", 32'(bus.tx_valid), 0);
        check("rst_rx_ready", 32'(bus.rx_ready), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_cart_ready", 32'(cart_ready), 0);
        check("rst_status", 32'(status), 0);
        check("rst_banks", 32'({prg_banks, chr_banks}), 0);
        check("rst_mirror", 32'(mirror_v), 0);
        rst = 1'b1;
        @(negedge clk);

        $display("[TB] basic PRG+CHR load");
        build(8'h01, 8'h01, 8'h01, 8'h00, 1, 1);
        checkOutput("basic", -1, 0, 0, nw);
        check("basic_nwrites", 32'(nw), 24);
        check("basic_status_lit", 32'(status), 'h53);
        check("basic_prg_banks", 32'(prg_banks), 1);
        check("basic_chr_banks", 32'(chr_banks), 1);
        check("basic_mirror", 32'(mirror_v), 1);
        check("basic_cart_ready", 32'(cart_ready), 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk) begin bus.rx_valid = 1'b1; bus.rx_data = 8'hAA; end
        end
        @(negedge clk) bus.rx_valid = 1'b0;

        $display("[TB] magic mismatch");
        build(8'h01, 8'h01, 8'h01, 8'h00, 1, 1);
        img[2] = 8'h58;
        checkOutput("magic", -1, 0, 0, nw);
        check("magic_nwrites", 32'(nw), 0);
        check("magic_status_lit", 32'(status), 'h46);
        check("magic_busy", 32'(busy), 0);
        check("magic_rx_ready", 32'(bus.rx_ready), 0);

        $display("[TB] unsupported images");
        build(8'h03, 8'h01, 8'h00, 8'h00, 1, 1);
        checkOutput("prg_big", -1, 0, 0, nw);
        check("prg_big_nwrites", 32'(nw), 0);
        check("prg_big_status_lit", 32'(status), 'h4D);
        build(8'h01, 8'h01, 8'h10, 8'h00, 1, 1);
        checkOutput("mapper", -1, 0, 0, nw);
        check("mapper_nwrites", 32'(nw), 0);
        build(8'h01, 8'h01, 8'h04, 8'h00, 1, 1);
        checkOutput("trainer", -1, 0, 0, nw);
        check("trainer_nwrites", 32'(nw), 0);
        check("trainer_status_lit", 32'(status), 'h4D);

        $display("[TB] two PRG banks, no CHR");
        build(8'h02, 8'h00, 8'h00, 8'h00, 2, 0);
        checkOutput("prg2", -1, 0, 0, nw);
        check("prg2_nwrites", 32'(nw), 32);
        check("prg2_mirror", 32'(mirror_v), 0);

        $display("[TB] timeout after 5 PRG bytes");
        build(8'h01, 8'h01, 8'h01, 8'h00, 1, 1);
        checkOutput("tmo", 21, 60, 0, nw);
        check("tmo_nwrites", 32'(nw), 5);
        check("tmo_status_lit", 32'(status), 'h54);
        build(8'h01, 8'h01, 8'h00, 8'h00, 1, 1);
        checkOutput("after_tmo", -1, 0, 0, nw);
        check("after_tmo_nwrites", 32'(nw), 24);

        $display("[TB] status held while tx_ready low");
        build(8'h01, 8'h00, 8'h00, 8'h00, 1, 0);
        checkOutput("hold", -1, 0, 20, nw);
        check("hold_nwrites", 32'(nw), 16);

        $display("[TB] reset during PRG");
        build(8'h02, 8'h00, 8'h00, 8'h00, 2, 0);
        model(-1, 0);
        pulse_start();
        applyStimulus(-1, 0, 26);
        @(posedge clk);
        #1;
        check("pre_reset_we", 32'(bus.prog_we), 1);
        #2 rst = 1'b0;
        #1;
        check("midrst_prog_we", 32'(bus.prog_we), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_rx_ready", 32'(bus.rx_ready), 0);
        check("midrst_tx_valid", 32'(bus.tx_valid), 0);
        check("midrst_status", 32'(status), 0);
        check("midrst_prog", 32'({bus.prog_sel, bus.prog_addr, bus.prog_data}), 0);
        check("midrst_banks", 32'({prg_banks, chr_banks}), 0);
        bus.rx_valid = 1'b0;
        exp_q.delete();
        @(negedge clk) rst = 1'b1;
        build(8'h01, 8'h01, 8'h01, 8'h00, 1, 1);
        checkOutput("after_rst", -1, 0, 0, nw);
        check("after_rst_nwrites", 32'(nw), 24);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
